id_ex_stage: RTL

ID/EX pipeline register for the 5-stage RISC-V core, with load-use hazard detection and register-file write-through bypass.
- Captures decoded operands and control each cycle, inserts bubbles on load-use hazards, and freezes or flushes on request.
- Its ex_rs1/ex_rs2/ex_rd/ex_reg_write outputs feed the EX-stage forwarding unit and operand muxes.
- The write-through bypass covers the WB-to-ID case, which EX forwarding cannot reach.

---
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/freeze control and
// a WB-to-ID register-file write-through bypass.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [CTRL_W-1:0] ctrl;
  } ex_regs_t;

  ex_regs_t         ex_q, ex_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             rs1_match, rs2_match, hazard;
  logic             bypass_rs1, bypass_rs2;

  // A load in EX whose destination the ID instruction actually reads.
  always_comb begin
    rs1_match = id_uses_rs1 && (id_rs1 == ex_q.rd);
    rs2_match = id_uses_rs2 && (id_rs2 == ex_q.rd);
    hazard    = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                (rs1_match || rs2_match);
  end

  always_comb begin
    load_use_stall = hazard && !flush && !mem_stall;
    pc_write_en    = !mem_stall && !load_use_stall;
    if_id_write_en = !mem_stall && !load_use_stall;
  end

  // WB writes the register file in the same cycle ID reads it; x0 is never bypassed.
  always_comb begin
    bypass_rs1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    bypass_rs2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);
  end

  // mem_stall outranks flush so a branch sitting in EX is never killed.
  always_comb begin
    ex_d = ex_q;
    if (!mem_stall) begin
      if (flush || load_use_stall) begin
        ex_d = '0;
      end else begin
        ex_d.valid     = id_valid;
        ex_d.pc        = id_pc;
        ex_d.rs1_data  = bypass_rs1 ? wb_data : id_rs1_data;
        ex_d.rs2_data  = bypass_rs2 ? wb_data : id_rs2_data;
        ex_d.imm       = id_imm;
        ex_d.rs1       = id_rs1;
        ex_d.rs2       = id_rs2;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        ex_d.mem_write = id_mem_write;
        ex_d.ctrl      = id_ctrl;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (load_use_stall && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    ex_valid     = ex_q.valid;
    ex_pc        = ex_q.pc;
    ex_rs1_data  = ex_q.rs1_data;
    ex_rs2_data  = ex_q.rs2_data;
    ex_imm       = ex_q.imm;
    ex_rs1       = ex_q.rs1;
    ex_rs2       = ex_q.rs2;
    ex_rd        = ex_q.rd;
    ex_reg_write = ex_q.reg_write;
    ex_mem_read  = ex_q.mem_read;
    ex_mem_write = ex_q.mem_write;
    ex_ctrl      = ex_q.ctrl;
    stall_count  = stall_q;
  end

endmodule
